// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts one tagged ALU command, launches registered operands
// into an external combinational ALU, waits a fixed settle time, then returns the
// captured result with zero/error flags over a response handshake.
module alu_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [3:0]        cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [3:0]        rsp_tag,
  output logic              busy
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_aluA;
  logic [DATA_W-1:0]   r_aluB;
  logic [3:0]          r_aluSel;
  logic [DATA_W-1:0]   r_rspResult;
  logic                r_rspCarry;
  logic                r_rspZero;
  logic                r_rspErr;
  logic [3:0]          r_rspTag;

  logic w_accept;
  logic w_divZero;
  logic w_expire;
  logic w_rspDone;
  logic w_carryOp;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_divZero = (cmd_op == 4'h3) && (cmd_b == '0);
  assign w_expire  = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
  assign w_rspDone = (r_state == S_RESP) && rsp_ready;
  // Only ADD and SUB produce a meaningful carry/borrow; the operand launch
  // registers still hold the opcode of the command being captured.
  assign w_carryOp = (r_aluSel == 4'h0) || (r_aluSel == 4'h1);

  // State register; an abandoned command simply vanishes on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: divide-by-zero skips the ALU and goes straight to the response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_divZero ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_expire) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rspDone) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand launch, settle counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluSel    <= '0;
      r_rspResult <= '0;
      r_rspCarry  <= 1'b0;
      r_rspZero   <= 1'b0;
      r_rspErr    <= 1'b0;
      r_rspTag    <= '0;
    end else begin
      if (w_accept) begin
        r_rspTag <= cmd_tag;
        if (w_divZero) begin
          r_rspResult <= '1;
          r_rspCarry  <= 1'b0;
          r_rspZero   <= 1'b0;
          r_rspErr    <= 1'b1;
        end else begin
          r_aluA   <= cmd_a;
          r_aluB   <= cmd_b;
          r_aluSel <= cmd_op;
          r_cnt    <= CNT_W'(WAIT_CYCLES);
        end
      end else if (r_state == S_WAIT) begin
        if (w_expire) begin
          r_rspResult <= alu_result;
          r_rspCarry  <= w_carryOp ? alu_carry : 1'b0;
          r_rspZero   <= (alu_result == '0);
          r_rspErr    <= 1'b0;
        end
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_sel    = r_aluSel;
  assign rsp_result = r_rspResult;
  assign rsp_carry  = r_rspCarry;
  assign rsp_zero   = r_rspZero;
  assign rsp_err    = r_rspErr;
  assign rsp_tag    = r_rspTag;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: drives directed commands into alu_cmd_sequencer with a
// behavioural ALU attached, and checks every cycle against a transaction model.
module tb_alu_cmd_sequencer;

  localparam int DATA_W      = 8;
  localparam int WAIT_CYCLES = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [3:0]        cmd_tag;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic              rsp_err;
  logic [3:0]        rsp_tag;
  logic              busy;

  int totalChecks = 0;
  int passChecks  = 0;

  typedef struct {
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       err;
    logic [3:0] tag;
  } rsp_t;

  rsp_t       expQ[$];
  logic       mOutstanding = 1'b0;
  int         mReadyAt     = 0;
  int         negCount     = 0;
  logic [7:0] mA           = '0;
  logic [7:0] mB           = '0;
  logic [3:0] mSel         = '0;

  alu_cmd_sequencer #(.DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: returns {carry, result}. Non-arithmetic ops still
  // raise a carry now and then so that masking in the sequencer is exercised.
  function automatic logic [8:0] refAlu(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'h0: refAlu = {1'b0, a} + {1'b0, b};
      4'h1: refAlu = {(a < b), a - b};
      4'h2: refAlu = {(p[15:8] != 8'h00), p[7:0]};
      4'h3: refAlu = (b == 8'h00) ? 9'h0FF : {1'b0, a / b};
      4'h4: refAlu = {a[0], a >> 1};
      4'h5: refAlu = {a[7], a << 1};
      4'h6: refAlu = {a[7], a[6:0], a[7]};
      4'h7: refAlu = {b[0], b[0], b[7:1]};
      4'h8: refAlu = {1'b0, 7'b0, (a > b)};
      4'h9: refAlu = {1'b0, 7'b0, (a < b)};
      4'hA: refAlu = {1'b0, a & b};
      4'hB: refAlu = {1'b1, ~(a & b)};
      4'hC: refAlu = {1'b0, a | b};
      4'hD: refAlu = {1'b1, ~(a | b)};
      4'hE: refAlu = {1'b0, a ^ b};
      default: refAlu = {1'b0, ~(a ^ b)};
    endcase
  endfunction

  // The ALU instance the sequencer talks to.
  always_comb begin
    {alu_carry, alu_result} = refAlu(alu_sel, alu_a, alu_b);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What a command must produce, from the command alone.
  function automatic rsp_t expectRsp(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [3:0] tag);
    rsp_t r;
    logic [8:0] v;
    v = refAlu(op, a, b);
    r.tag = tag;
    if (op == 4'h3 && b == 8'h00) begin
      r.result = 8'hFF;
      r.carry  = 1'b0;
      r.zero   = 1'b0;
      r.err    = 1'b1;
    end else begin
      r.result = v[7:0];
      r.carry  = (op == 4'h0 || op == 4'h1) ? v[8] : 1'b0;
      r.zero   = (v[7:0] == 8'h00);
      r.err    = 1'b0;
    end
    return r;
  endfunction

  // Transaction model: one command in flight at a time, response visible
  // WAIT_CYCLES edges after acceptance (immediately for divide by zero).
  always @(negedge clk) begin
    logic expValid;
    logic dz;
    negCount++;
    if (!rst_n) begin
      mOutstanding = 1'b0;
      mA = '0;
      mB = '0;
      mSel = '0;
      expQ.delete();
      checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
      checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstAluSel", 32'(alu_sel), 32'd0);
      checkOutput("rstAluA", 32'(alu_a), 32'd0);
      checkOutput("rstRspResult", 32'(rsp_result), 32'd0);
      checkOutput("rstRspTag", 32'(rsp_tag), 32'd0);
    end else begin
      expValid = mOutstanding && (negCount >= mReadyAt);
      checkOutput("mdlCmdReady", 32'(cmd_ready), 32'(!mOutstanding));
      checkOutput("mdlBusy", 32'(busy), 32'(mOutstanding));
      checkOutput("mdlRspValid", 32'(rsp_valid), 32'(expValid));
      checkOutput("mdlAluA", 32'(alu_a), 32'(mA));
      checkOutput("mdlAluB", 32'(alu_b), 32'(mB));
      checkOutput("mdlAluSel", 32'(alu_sel), 32'(mSel));
      if (expValid && rsp_valid && expQ.size() > 0) begin
        checkOutput("mdlRspResult", 32'(rsp_result), 32'(expQ[0].result));
        checkOutput("mdlRspCarry", 32'(rsp_carry), 32'(expQ[0].carry));
        checkOutput("mdlRspZero", 32'(rsp_zero), 32'(expQ[0].zero));
        checkOutput("mdlRspErr", 32'(rsp_err), 32'(expQ[0].err));
        checkOutput("mdlRspTag", 32'(rsp_tag), 32'(expQ[0].tag));
      end
      if (expValid && rsp_ready) begin
        mOutstanding = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_front());
      end else if (!mOutstanding && cmd_valid) begin
        dz = (cmd_op == 4'h3) && (cmd_b == 8'h00);
        expQ.push_back(expectRsp(cmd_op, cmd_a, cmd_b, cmd_tag));
        mOutstanding = 1'b1;
        mReadyAt = negCount + 1 + (dz ? 0 : WAIT_CYCLES);
        if (!dz) begin
          mA = cmd_a;
          mB = cmd_b;
          mSel = cmd_op;
        end
      end
    end
  end

  // Present a command and hold it until the sequencer takes it; returns just
  // after the accepting edge with cmd_valid dropped.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] tag);
    bit taken;
    taken = 1'b0;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_tag = tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until a response is on the outputs.
  task automatic waitRsp();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("rspTimeout", 32'd0, 32'd1);
  endtask

  logic [3:0] vecOp[10] = '{4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'h3, 4'h4, 4'hD};
  logic [7:0] vecA[10]  = '{8'h10, 8'h80, 8'h81, 8'h00, 8'h05, 8'h05, 8'hFF, 8'h64, 8'h81, 8'h0F};
  logic [7:0] vecB[10]  = '{8'h10, 8'h01, 8'h00, 8'h01, 8'h03, 8'h03, 8'hFF, 8'h07, 8'h00, 8'hF0};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_tag = '0;
    rsp_ready = 1'b1;

    // Pin the reference model with hand-worked values.
    checkOutput("pinAdd", 32'(refAlu(4'h0, 8'hF0, 8'h20)), 32'h110);
    checkOutput("pinXor", 32'(refAlu(4'hE, 8'hAA, 8'h0F)), 32'h0A5);
    checkOutput("pinRor", 32'(refAlu(4'h7, 8'h00, 8'h01)), 32'h180);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with carry out, one-cycle settle.
    applyStimulus(4'h0, 8'hF0, 8'h20, 4'd3);
    @(negedge clk);
    checkOutput("addLatencyLow", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("addValid", 32'(rsp_valid), 32'd1);
    checkOutput("addResult", 32'(rsp_result), 32'h10);
    checkOutput("addCarry", 32'(rsp_carry), 32'd1);
    checkOutput("addZero", 32'(rsp_zero), 32'd0);
    checkOutput("addErr", 32'(rsp_err), 32'd0);
    checkOutput("addTag", 32'(rsp_tag), 32'd3);
    @(posedge clk);
    #1;

    // SUB to zero.
    applyStimulus(4'h1, 8'h05, 8'h05, 4'd7);
    @(negedge clk);
    @(negedge clk);
    checkOutput("subResult", 32'(rsp_result), 32'h00);
    checkOutput("subZero", 32'(rsp_zero), 32'd1);
    checkOutput("subCarry", 32'(rsp_carry), 32'd0);
    @(posedge clk);
    #1;

    // Divide by zero: immediate response, ALU operands untouched.
    applyStimulus(4'h3, 8'h10, 8'h00, 4'd4);
    @(negedge clk);
    checkOutput("dzValid", 32'(rsp_valid), 32'd1);
    checkOutput("dzResult", 32'(rsp_result), 32'hFF);
    checkOutput("dzErr", 32'(rsp_err), 32'd1);
    checkOutput("dzAluA", 32'(alu_a), 32'h05);
    checkOutput("dzAluB", 32'(alu_b), 32'h05);
    checkOutput("dzAluSel", 32'(alu_sel), 32'h1);
    @(posedge clk);
    #1;

    // XOR with back-pressure and a second command waiting behind it.
    rsp_ready = 1'b0;
    applyStimulus(4'hE, 8'hAA, 8'h0F, 4'd5);
    cmd_op = 4'h0;
    cmd_a = 8'h01;
    cmd_b = 8'h02;
    cmd_tag = 4'd6;
    cmd_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("xorHoldValid", 32'(rsp_valid), 32'd1);
      checkOutput("xorHoldResult", 32'(rsp_result), 32'hA5);
      checkOutput("xorHoldCarry", 32'(rsp_carry), 32'd0);
      checkOutput("xorHoldReady", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("xorHsCmdReady", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("secondIdle", 32'(cmd_ready), 32'd1);
    checkOutput("secondNoRsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("secondBusy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("secondResult", 32'(rsp_result), 32'h03);
    checkOutput("secondTag", 32'(rsp_tag), 32'd6);
    @(posedge clk);
    #1;

    // Directed vectors across the remaining opcodes; the model checks them.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecOp[i], vecA[i], vecB[i], 4'(i));
      waitRsp();
      @(posedge clk);
      #1;
    end

    // Reset while a response is held.
    rsp_ready = 1'b0;
    applyStimulus(4'hA, 8'h3C, 8'h0F, 4'd9);
    @(negedge clk);
    @(negedge clk);
    checkOutput("preRstValid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(rsp_valid), 32'd0);
    checkOutput("midRstReady", 32'(cmd_ready), 32'd1);
    checkOutput("midRstSel", 32'(alu_sel), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Reset during the settle wait: nothing comes out afterwards.
    applyStimulus(4'h0, 8'h11, 8'h22, 4'd2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("waitRstReady", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("waitRstNoRsp", 32'(rsp_valid), 32'd0);
      checkOutput("waitRstIdle", 32'(cmd_ready), 32'd1);
    end
    @(posedge clk);
    #1;

    // Still usable afterwards.
    applyStimulus(4'hC, 8'h50, 8'h05, 4'd1);
    waitRsp();
    checkOutput("postRstResult", 32'(rsp_result), 32'h55);
    @(posedge clk);
    #1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
